fifo_rd_ctrl: RTL
=================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter Width, default 8, data width of FIFO read data and output stream.
REQ-002 Parameter Depth_Size, default 4, FIFO address bits; fifo_counter is Depth_Size+1 bits.
REQ-003 Parameter Burst_Len, default 4, maximum beats drained per burst (range 1..2**Depth_Size).
REQ-004 Parameter Timeout, default 15, idle cycles with a non-empty FIFO before a short burst is forced (range 1..255).
REQ-005 Clk  input  1  single clock, FIFO read-side clock; all state on rising edge.
REQ-006 Rst_n  input  1  asynchronous active-low reset.
REQ-007 fifo_empty  input  1  FIFO empty flag, read domain.
REQ-008 fifo_counter  input  Depth_Size+1  FIFO occupancy, read domain.
REQ-009 fifo_out  input  Width  FIFO read data, valid the cycle after rd_en is sampled high.
REQ-010 rd_en  output  1  FIFO read strobe.
REQ-011 out_data  output  Width  stream data.
REQ-012 out_valid  output  1  stream valid.
REQ-013 out_last  output  1  marks final beat of a burst; qualified by out_valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 States IDLE and BURST; rd_en SHALL be asserted only in BURST.
REQ-016 IDLE->BURST when fifo_counter >= Burst_Len, or when idle timer == Timeout and fifo_empty == 0.
REQ-017 Idle timer (8 bit) increments each IDLE cycle with fifo_empty == 0, saturates at Timeout, clears on fifo_empty == 1 and on entering BURST.
REQ-018 In BURST, rd_en = (fifo_empty == 0) && (occ + inflight <= 2), combinationally; occ = output buffer entries, inflight = rd_en registered one cycle.
REQ-019 Beat counter clears on entering BURST, increments per cycle with rd_en high.
REQ-020 An issued beat is tagged last when beat counter == Burst_Len-1 or fifo_counter == 1 at issue.
REQ-021 BURST->IDLE on the cycle the last-tagged beat is issued.
REQ-022 BURST->IDLE also when fifo_empty == 1 and no beat issued; the most recently issued beat SHALL then already carry last, else out_last is asserted on no beat and that burst is unterminated (permitted, not an error).
REQ-023 Output buffer: 3-entry in-order FIFO of {data, last}; entry written from fifo_out the cycle after rd_en, with captured last tag.
REQ-024 out_valid = (occ != 0); out_data/out_last = head entry; pop on out_valid && out_ready; simultaneous push and pop keep occ unchanged.
REQ-025 Buffer SHALL never overflow; REQ-018 guarantees occ <= 3 with no pop lookahead.
REQ-026 With out_ready held high and FIFO non-empty, sustained throughput SHALL be one beat per Clk; first out_valid 2 cycles after entering BURST.
REQ-027 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-028 No data loss or reordering: output stream equals FIFO read order exactly.

Reset
REQ-029 Rst_n low: state IDLE, timer, beat counter, inflight, occ cleared; rd_en, out_valid, out_last = 0 immediately.
REQ-030 Reset mid-burst discards buffered and in-flight beats; no partial beat emitted after release.
REQ-031 First rd_en no earlier than the second rising Clk edge after Rst_n deasserts.

Verification
REQ-032 fifo_counter=8, data 1..8, out_ready=1 -> two bursts of 4: out_data 1,2,3,4 (last on 4) and 5,6,7,8 (last on 8), one beat per cycle within a burst.
REQ-033 fifo_counter=2 held, no writes -> 15 idle cycles, then BURST: 2 beats, last on 2nd (via fifo_counter==1 at issue).
REQ-034 Burst active, out_ready=0 for 10 cycles -> rd_en stops after occ+inflight reaches 3, out_data frozen, no beat lost on out_ready=1.
REQ-035 Rst_n pulsed low mid-burst with occ=2 -> rd_en/out_valid drop asynchronously; after release, timer restarts from 0 and only new reads appear.
REQ-036 Random fifo_empty/out_ready toggling, 1000 beats -> scoreboard: exact order, occ never >3, rd_en never high with fifo_empty=1.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side burst controller.
// Drains a FIFO in bursts of up to Burst_Len beats into a valid/ready stream.
// A burst also starts early when data has been sitting for Timeout idle cycles.
// A 3-entry skid buffer absorbs the one-cycle FIFO read latency and backpressure.
module fifo_rd_ctrl #(
    parameter int Width      = 8,
    parameter int Depth_Size = 4,
    parameter int Burst_Len  = 4,
    parameter int Timeout    = 15
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  fifo_empty,
    input  logic [Depth_Size:0]   fifo_counter,
    input  logic [Width-1:0]      fifo_out,
    output logic                  rd_en,
    output logic [Width-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int CW = Depth_Size + 1;
    localparam logic [CW-1:0] BURST_LEN_C = CW'(Burst_Len);
    localparam logic [CW-1:0] LAST_BEAT_C = CW'(Burst_Len - 1);
    localparam logic [CW-1:0] ONE_C       = CW'(1);
    localparam logic [7:0]    TIMEOUT_C   = 8'(Timeout);

    typedef enum logic {IDLE, BURST} state_e;

    state_e             state_q, state_d;
    logic               start_burst;
    logic               issue_last;
    logic               pop;
    logic               push;
    logic [1:0]         wr_idx;

    logic [7:0]         timer_q, timer_d;
    logic [CW-1:0]      beat_q, beat_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic [1:0]         occ_q, occ_d;
    logic [Width-1:0]   buf_data_q [3];
    logic [Width-1:0]   buf_data_d [3];
    logic [2:0]         buf_last_q, buf_last_d;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter a burst on enough data or on idle timeout; leave on the last beat or on empty
    always_comb begin
        state_d     = state_q;
        start_burst = 1'b0;
        case (state_q)
            IDLE: begin
                if ((fifo_counter >= BURST_LEN_C) ||
                    ((timer_q == TIMEOUT_C) && !fifo_empty)) begin
                    state_d     = BURST;
                    start_burst = 1'b1;
                end
            end
            BURST: begin
                if (issue_last || (fifo_empty && !rd_en)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: read only while the buffer plus the in-flight beat leaves room for one more
    always_comb begin
        rd_en      = (state_q == BURST) && !fifo_empty &&
                     (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);
        issue_last = rd_en && ((beat_q == LAST_BEAT_C) || (fifo_counter == ONE_C));
        out_valid  = (occ_q != 2'd0);
        out_data   = buf_data_q[0];
        out_last   = out_valid && buf_last_q[0];
    end

    // Idle timer, beat counter and read-latency tracking
    always_comb begin
        timer_d         = timer_q;
        beat_d          = beat_q;
        inflight_d      = rd_en;
        inflight_last_d = issue_last;
        if (state_q == IDLE) begin
            beat_d = '0;
            if (fifo_empty || start_burst) begin
                timer_d = '0;
            end else if (timer_q < TIMEOUT_C) begin
                timer_d = timer_q + 8'd1;
            end
        end else begin
            timer_d = '0;
            if (rd_en) begin
                beat_d = beat_q + ONE_C;
            end
        end
    end

    // Skid buffer: head at entry 0; a pop shifts down, so the push slot is occ minus the pop
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        pop        = out_valid && out_ready;
        push       = inflight_q;
        wr_idx     = occ_q - {1'b0, pop};
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_data_d[1] = buf_data_q[2];
            buf_last_d[0] = buf_last_q[1];
            buf_last_d[1] = buf_last_q[2];
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (push && (wr_idx == 2'(i))) begin
                buf_data_d[i] = fifo_out;
                buf_last_d[i] = inflight_last_q;
            end
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Datapath registers; reset drops buffered and in-flight beats
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            timer_q         <= '0;
            beat_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= '0;
            buf_data_q      <= '{default: '0};
            buf_last_q      <= '0;
        end else begin
            timer_q         <= timer_d;
            beat_q          <= beat_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            buf_data_q      <= buf_data_d;
            buf_last_q      <= buf_last_d;
        end
    end

endmodule
